// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM encoding for the UART echo datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Character width carried between uart_rx and uart_tx
    localparam int UART_DATA_W   = 8;

    // Baud-tick divisor: 50 MHz / (16 * 19200) ~= 163
    localparam int UART_BAUD_DIV = 163;

    // Transmit-buffer drain FSM encoding
    typedef logic [0:0] tx_state_t;
    localparam tx_state_t c_st_idle = 1'b0;
    localparam tx_state_t c_st_busy = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy counter. dout always shows
//               the entry at the read pointer (first-word fall-through).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    // A push into a full FIFO still fits when a pop frees a slot this cycle
    assign w_push_ok = push && (!full || w_pop_ok);
    assign w_pop_ok  = pop && !empty;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffer
// Description : Queues received characters and feeds them to uart_tx one at
//               a time: one-cycle tx_start per byte, then wait for
//               tx_done_tick. Dropped pushes latch a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_done_tick,
    input  logic              clr_overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    tx_state_t         r_state;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_overflow;
    logic              w_pop;
    logic              w_drop;
    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W:0]   w_count;

    // The only pop is the IDLE->BUSY hand-off of the head byte
    assign w_pop  = (r_state == c_st_idle) && !w_empty;
    assign w_drop = rx_done_tick && w_full && !w_pop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_done_tick),
        .pop   (w_pop),
        .din   (rx_data),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Drain FSM: latch head byte and pulse tx_start, then hold until done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) begin
                        r_tx_data  <= w_fifo_dout;
                        r_tx_start <= 1'b1;
                        r_state    <= c_st_busy;
                    end else begin
                        r_tx_start <= 1'b0;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    if (tx_done_tick) begin
                        r_state <= c_st_idle;
                    end
                end
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign overflow = r_overflow;
    assign count    = w_count;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffer
// Description : Directed self-checking bench for uart_tx_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       tx_done_tick;
    logic       clr_overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sent [$];
    logic       r_prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DATA_W (8),
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .tx_done_tick (tx_done_tick),
        .clr_overflow (clr_overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_done_tick = 1'b1;
        rx_data      = d;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic done();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    // done tick, one idle cycle, then the next byte must start
    task automatic done_then_expect(input string tag, input logic [7:0] exp);
        done();
        check({tag, "_gap"}, tx_start, 1'b0);
        tick();
        check({tag, "_start"}, tx_start, 1'b1);
        check({tag, "_data"}, tx_data, exp);
    endtask

    // Record every start pulse and confirm it lasts exactly one cycle
    always @(negedge clk) begin
        if (tx_start) begin
            sent.push_back(tx_data);
            check("start_width", r_prev_start, 1'b0);
        end
        r_prev_start <= tx_start;
    end

    initial begin
        logic [7:0] v;
        int         exp_v;
        int         n;

        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        tx_done_tick = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_ovf", overflow, 0);

        // 1: single byte
        push(8'h41);
        check("t1_cnt1", count, 1);
        check("t1_nostart", tx_start, 0);
        tick();
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'h41);
        check("t1_cnt0", count, 0);
        tick();
        check("t1_pulse_end", tx_start, 0);
        tick();
        tick();
        check("t1_hold", tx_data, 8'h41);
        done();
        tick();
        check("t1_idle", tx_start, 0);
        check("t1_empty", empty, 1);

        // 2: burst of three
        push(8'h10);
        push(8'h11);
        push(8'h12);
        check("t2_cnt", count, 2);
        check("t2_first", tx_data, 8'h10);
        tick();
        tick();
        done_then_expect("t2_b1", 8'h11);
        tick();
        done_then_expect("t2_b2", 8'h12);
        done();
        tick();
        check("t2_empty", empty, 1);

        // 3: fill, overflow, ordered drain, clear
        for (int i = 0; i < 18; i++) push(8'(i));
        check("t3_cnt", count, 16);
        check("t3_full", full, 1);
        check("t3_ovf", overflow, 1);
        check("t3_first", tx_data, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            done_then_expect("t3_drain", 8'(i));
            if (i == 1) check("t3_cnt15", count, 15);
        end
        done();
        tick();
        check("t3_empty", empty, 1);
        check("t3_ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // 4: drop vs clear priority, then push on the pop cycle when full
        for (int i = 0; i < 17; i++) push(8'(8'h20 + i));
        check("t4_full", full, 1);
        check("t4_ovf0", overflow, 0);
        clr_overflow = 1'b1;
        push(8'h99);
        clr_overflow = 1'b0;
        check("t4_setwins", overflow, 1);
        check("t4_cnt_drop", count, 16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t4_clr", overflow, 0);
        done();
        check("t4_gap", tx_start, 0);
        push(8'h31);
        check("t4_start", tx_start, 1);
        check("t4_data", tx_data, 8'h21);
        check("t4_cnt", count, 16);
        check("t4_full2", full, 1);
        check("t4_ovf_keep", overflow, 0);
        for (int i = 8'h22; i <= 8'h31; i++) done_then_expect("t4_drain", 8'(i));
        done();
        tick();
        check("t4_empty", empty, 1);

        // 5: 40 bytes in chunks of five, pointers wrap repeatedly
        sent.delete();
        exp_v = 0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 5; k++) push(8'(c * 5 + k));
            for (int k = 0; k < 5; k++) begin
                n = 0;
                while (sent.size() == 0 && n < 20) begin
                    tick();
                    n++;
                end
                if (sent.size() == 0) begin
                    check("t5_timeout", 0, 1);
                end else begin
                    v = sent.pop_front();
                    check("t5_seq", v, 8'(exp_v));
                end
                exp_v++;
                done();
            end
        end
        tick();
        check("t5_empty", empty, 1);
        check("t5_extra", sent.size(), 0);

        // 6: asynchronous reset while busy with five queued
        for (int i = 0; i < 6; i++) push(8'(8'h51 + i));
        check("t6_cnt5", count, 5);
        check("t6_data", tx_data, 8'h51);
        #2;
        reset = 1'b1;
        #1;
        check("t6_start0", tx_start, 0);
        check("t6_cnt0", count, 0);
        check("t6_empty", empty, 1);
        check("t6_data0", tx_data, 0);
        tick();
        reset = 1'b0;
        sent.delete();
        tick();
        done();
        tick();
        tick();
        check("t6_stray", sent.size(), 0);
        check("t6_nostart", tx_start, 0);
        push(8'h77);
        tick();
        check("t6_fresh_start", tx_start, 1);
        check("t6_fresh_data", tx_data, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
